// File: rtl/clk_gen_pkg.sv
// Shared types for the clock/PWM generator.
//   state_t   : controller FSM state (2-bit)
//   cfg_t     : {period, high} configuration word
//   cfg_legal : range check applied to a granted configuration
package clk_gen_pkg;

    // Field width of cfg_t; the top-level CNT_W parameter must match it.
    localparam int CFG_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] high;
    } cfg_t;

    // A usable waveform needs at least one high and one low cycle per period.
    function automatic logic cfg_legal(input cfg_t c);
        return (c.period >= CFG_W'(2)) && (c.high != '0) && (c.high < c.period);
    endfunction

endpackage

// File: rtl/clk_gen_core.sv
// Period counter and duty compare for the generated clock.
//   clk_in     : clock
//   reset      : asynchronous, active-high reset
//   run        : 1 while the controller is in RUN or DRAIN
//   cur_period : active period (clk_in cycles)
//   cur_high   : active high-phase cycles
//   clk_out    : registered generated clock
//   wrap       : 1 in the last cycle of a period (counter == cur_period-1)
module clk_gen_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             run,
    input  logic [CNT_W-1:0] cur_period,
    input  logic [CNT_W-1:0] cur_high,
    output logic             clk_out,
    output logic             wrap
);

    logic [CNT_W-1:0] counter;

    assign wrap = run && (counter == cur_period - CNT_W'(1));

    // clk_out is compared against the pre-increment counter, so the
    // waveform lags the counter by one cycle and the first high cycle
    // follows the cycle in which RUN is entered.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            counter <= '0;
            clk_out <= 1'b0;
        end else begin
            if (!run || wrap)
                counter <= '0;
            else
                counter <= counter + CNT_W'(1);
            clk_out <= run && (counter < cur_high);
        end
    end

endmodule

// File: rtl/clk_gen_ctrl.sv
// Runtime-programmable clock/PWM generator with two-requester config port.
// Configs are arbitrated round-robin, range-checked, staged in a shadow
// register and applied at a period boundary (or immediately when idle).
//   clk_in, reset            : clock, asynchronous active-high reset
//   enable                   : 1 = run, 0 = drain to stop at end of period
//   reqN_valid/period/high   : requester N config (held until reqN_ready)
//   reqN_ready               : 1-cycle pulse, config N consumed
//   clk_out                  : generated clock (registered)
//   running                  : 1 in RUN or DRAIN
//   pending                  : accepted config waiting to be applied
//   cfg_err                  : 1-cycle pulse, granted config rejected
//   cur_period, cur_high     : active configuration
module clk_gen_ctrl
    import clk_gen_pkg::*;
#(
    parameter int CNT_W      = CFG_W,
    parameter int DEF_PERIOD = 10,
    parameter int DEF_HIGH   = 6
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             req0_valid,
    input  logic [CNT_W-1:0] req0_period,
    input  logic [CNT_W-1:0] req0_high,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [CNT_W-1:0] req1_period,
    input  logic [CNT_W-1:0] req1_high,
    output logic             req1_ready,
    output logic             clk_out,
    output logic             running,
    output logic             pending,
    output logic             cfg_err,
    output logic [CNT_W-1:0] cur_period,
    output logic [CNT_W-1:0] cur_high
);

    localparam cfg_t DEF_CFG = '{period: CNT_W'(DEF_PERIOD), high: CNT_W'(DEF_HIGH)};

    state_t state, state_nxt;
    cfg_t   cur, shadow, gnt_cfg;
    logic   rr_ptr;
    logic   gnt0, gnt1, grant, gnt_ok;
    logic   run, wrap, apply;

    assign run        = (state != IDLE);
    assign running    = run;
    assign cur_period = cur.period;
    assign cur_high   = cur.high;

    clk_gen_core #(.CNT_W(CNT_W)) u_core (
        .clk_in     (clk_in),
        .reset      (reset),
        .run        (run),
        .cur_period (cur.period),
        .cur_high   (cur.high),
        .clk_out    (clk_out),
        .wrap       (wrap)
    );

    // Grants stall while a config is staged, and while a ready pulse is
    // out: the requester still shows valid that cycle, so granting then
    // would accept the same config twice.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!pending && !req0_ready && !req1_ready) begin
            if (req0_valid && req1_valid) begin
                gnt0 = !rr_ptr;
                gnt1 = rr_ptr;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
        grant          = gnt0 || gnt1;
        gnt_cfg.period = gnt1 ? req1_period : req0_period;
        gnt_cfg.high   = gnt1 ? req1_high   : req0_high;
        gnt_ok         = cfg_legal(gnt_cfg);
    end

    // Staged config lands when idle, or on the last cycle of a period so
    // the next period starts at counter 0 under the new values.
    assign apply = pending && (!run || wrap);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = wrap ? IDLE : DRAIN;
            DRAIN:   if (enable) state_nxt = RUN;
                     else if (wrap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cur        <= DEF_CFG;
            shadow     <= DEF_CFG;
            pending    <= 1'b0;
            rr_ptr     <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            req0_ready <= gnt0;
            req1_ready <= gnt1;
            cfg_err    <= grant && !gnt_ok;
            // Point at the side that was not just served.
            if (grant)
                rr_ptr <= gnt0;
            // apply and grant are exclusive: grant requires !pending.
            if (apply) begin
                cur     <= shadow;
                pending <= 1'b0;
            end else if (grant && gnt_ok) begin
                shadow  <= gnt_cfg;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_gen_ctrl.sv
module tb_clk_gen_ctrl;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       enable;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_period, req0_high, req1_period, req1_high;
    logic       req0_ready, req1_ready;
    logic       clk_out, running, pending, cfg_err;
    logic [7:0] cur_period, cur_high;

    int tests = 0;
    int fails = 0;

    clk_gen_ctrl dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .enable      (enable),
        .req0_valid  (req0_valid),
        .req0_period (req0_period),
        .req0_high   (req0_high),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_period (req1_period),
        .req1_high   (req1_high),
        .req1_ready  (req1_ready),
        .clk_out     (clk_out),
        .running     (running),
        .pending     (pending),
        .cfg_err     (cfg_err),
        .cur_period  (cur_period),
        .cur_high    (cur_high)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       en, v0;
        logic [7:0] p0, h0;
        logic       clk, pend, rdy0;
        logic [7:0] per, hi;
    } vec_t;

    vec_t vt[27];

    function automatic vec_t mk(input logic en, v0, input logic [7:0] p0, h0,
                                input logic clk, pend, rdy0, input logic [7:0] per, hi);
        vec_t v;
        v.en = en; v.v0 = v0; v.p0 = p0; v.h0 = h0;
        v.clk = clk; v.pend = pend; v.rdy0 = rdy0; v.per = per; v.hi = hi;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        enable = 1'b0;
        req0_valid = 1'b0; req0_period = '0; req0_high = '0;
        req1_valid = 1'b0; req1_period = '0; req1_high = '0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
    endtask

    logic [7:0] bad_p[3];
    logic [7:0] bad_h[3];

    initial begin
        // ---- reset state ----
        reset = 1'b1;
        enable = 1'b0;
        req0_valid = 1'b0; req0_period = '0; req0_high = '0;
        req1_valid = 1'b0; req1_period = '0; req1_high = '0;
        #1;
        chk("reset_outputs", {clk_out, running, pending, cfg_err, req0_ready, req1_ready}, 6'b0);
        chk("reset_cfg", {cur_period, cur_high}, {8'd10, 8'd6});

        // ---- table: defaults 6/4, then req0 {4,1} mid-period ----
        //           en v0 p0 h0   clk pend rdy0 per  hi
        vt[0]  = mk(1, 0, 0, 0,   0,  0,   0,   10,  6);
        vt[1]  = mk(1, 0, 0, 0,   1,  0,   0,   10,  6);
        vt[2]  = mk(1, 0, 0, 0,   1,  0,   0,   10,  6);
        vt[3]  = mk(1, 0, 0, 0,   1,  0,   0,   10,  6);
        vt[4]  = mk(1, 0, 0, 0,   1,  0,   0,   10,  6);
        vt[5]  = mk(1, 0, 0, 0,   1,  0,   0,   10,  6);
        vt[6]  = mk(1, 0, 0, 0,   1,  0,   0,   10,  6);
        vt[7]  = mk(1, 0, 0, 0,   0,  0,   0,   10,  6);
        vt[8]  = mk(1, 0, 0, 0,   0,  0,   0,   10,  6);
        vt[9]  = mk(1, 0, 0, 0,   0,  0,   0,   10,  6);
        vt[10] = mk(1, 0, 0, 0,   0,  0,   0,   10,  6);
        vt[11] = mk(1, 0, 0, 0,   1,  0,   0,   10,  6);
        vt[12] = mk(1, 0, 0, 0,   1,  0,   0,   10,  6);
        vt[13] = mk(1, 1, 4, 1,   1,  1,   1,   10,  6);
        vt[14] = mk(1, 0, 0, 0,   1,  1,   0,   10,  6);
        vt[15] = mk(1, 0, 0, 0,   1,  1,   0,   10,  6);
        vt[16] = mk(1, 0, 0, 0,   1,  1,   0,   10,  6);
        vt[17] = mk(1, 0, 0, 0,   0,  1,   0,   10,  6);
        vt[18] = mk(1, 0, 0, 0,   0,  1,   0,   10,  6);
        vt[19] = mk(1, 0, 0, 0,   0,  1,   0,   10,  6);
        vt[20] = mk(1, 0, 0, 0,   0,  0,   0,    4,  1);
        vt[21] = mk(1, 0, 0, 0,   1,  0,   0,    4,  1);
        vt[22] = mk(1, 0, 0, 0,   0,  0,   0,    4,  1);
        vt[23] = mk(1, 0, 0, 0,   0,  0,   0,    4,  1);
        vt[24] = mk(1, 0, 0, 0,   0,  0,   0,    4,  1);
        vt[25] = mk(1, 0, 0, 0,   1,  0,   0,    4,  1);
        vt[26] = mk(1, 0, 0, 0,   0,  0,   0,    4,  1);

        @(negedge clk_in);
        reset = 1'b0;
        for (int i = 0; i < 27; i++) begin
            enable = vt[i].en;
            req0_valid = vt[i].v0; req0_period = vt[i].p0; req0_high = vt[i].h0;
            tick();
            chk($sformatf("table_row%0d", i),
                {10'd0, clk_out, running, pending, req0_ready, req1_ready, cfg_err, cur_period, cur_high},
                {10'd0, vt[i].clk, 1'b1, vt[i].pend, vt[i].rdy0, 1'b0, 1'b0, vt[i].per, vt[i].hi});
        end

        // ---- round-robin arbitration (idle) ----
        do_reset();
        req0_valid = 1; req0_period = 8; req0_high = 2;
        req1_valid = 1; req1_period = 6; req1_high = 3;
        tick();
        chk("rr_first_req0", {req0_ready, req1_ready, pending}, 3'b101);
        req0_period = 7; req0_high = 3;   // requester 0 immediately offers another
        tick();
        chk("rr_apply_8_2", {req0_ready, pending, cur_period, cur_high}, {2'b00, 8'd8, 8'd2});
        tick();
        chk("rr_pair_req1", {req0_ready, req1_ready, pending}, 3'b011);
        req1_valid = 0;
        tick();
        chk("rr_apply_6_3", {pending, cur_period, cur_high}, {1'b0, 8'd6, 8'd3});
        tick();
        chk("rr_then_req0", {req0_ready, req1_ready, pending}, 3'b101);
        req0_valid = 0;
        tick();
        chk("rr_apply_7_3", {pending, cur_period, cur_high}, {1'b0, 8'd7, 8'd3});

        // ---- illegal configs on requester 1 ----
        do_reset();
        bad_p[0] = 5; bad_h[0] = 5;
        bad_p[1] = 1; bad_h[1] = 0;
        bad_p[2] = 0; bad_h[2] = 0;
        for (int i = 0; i < 3; i++) begin
            req1_valid = 1; req1_period = bad_p[i]; req1_high = bad_h[i];
            tick();
            chk($sformatf("bad%0d_err", i), {req1_ready, cfg_err, pending}, 3'b110);
            req1_valid = 0;
            tick();
            chk($sformatf("bad%0d_clear", i), {req1_ready, cfg_err, pending, cur_period, cur_high},
                {3'b000, 8'd10, 8'd6});
        end
        // smallest legal config
        req1_valid = 1; req1_period = 2; req1_high = 1;
        tick();
        chk("min_legal_accept", {req1_ready, cfg_err, pending}, 3'b101);
        req1_valid = 0;
        tick();
        chk("min_legal_apply", {pending, cur_period, cur_high}, {1'b0, 8'd2, 8'd1});

        // ---- drain to stop ----
        do_reset();
        enable = 1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            chk($sformatf("drain_e%0d", n), {clk_out, running},
                {(n >= 2 && n <= 7), (n <= 10)});
            if (n == 3) enable = 0;
        end

        // ---- re-enable during drain: waveform uninterrupted ----
        do_reset();
        enable = 1;
        for (int n = 1; n <= 21; n++) begin
            tick();
            chk($sformatf("reen_e%0d", n), {clk_out, running},
                {(n >= 2) && (((n - 2) % 10) < 6), 1'b1});
            if (n == 3) enable = 0;
            if (n == 5) enable = 1;
        end

        // ---- async reset mid-period with a staged config ----
        do_reset();
        enable = 1;
        tick();
        req0_valid = 1; req0_period = 4; req0_high = 1;
        tick();
        chk("rst_pending_set", {req0_ready, pending}, 2'b11);
        req0_valid = 0;
        tick();
        tick();
        chk("rst_pre_high", clk_out, 1'b1);
        #2 reset = 1;
        #1;
        chk("rst_async", {clk_out, running, pending, cur_period, cur_high},
            {3'b000, 8'd10, 8'd6});
        @(negedge clk_in);
        reset = 0;
        tick();
        chk("rst_release", {running, pending, cur_period, cur_high}, {2'b10, 8'd10, 8'd6});
        tick();
        chk("rst_default_high", clk_out, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
